// File: rtl/port_b_shift_out_if.sv
// rtl/port_b_shift_out_if.sv - port B input and 74HC595-style serial output signal bundle
interface port_b_shift_out_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] port_b_in;
    logic             enable;
    logic             sr_ser;
    logic             sr_sck;
    logic             sr_rck;
    logic             busy;
    logic [WIDTH-1:0] shadow_q;
    logic [7:0]       drop_cnt;

    // CPU / environment side
    modport master (
        output port_b_in,
        output enable,
        input  sr_ser,
        input  sr_sck,
        input  sr_rck,
        input  busy,
        input  shadow_q,
        input  drop_cnt
    );

    // serialiser side
    modport slave (
        input  port_b_in,
        input  enable,
        output sr_ser,
        output sr_sck,
        output sr_rck,
        output busy,
        output shadow_q,
        output drop_cnt
    );
endinterface

// File: rtl/port_b_shift_out.sv
// rtl/port_b_shift_out.sv - serialises port B changes to an external shift/latch register
module port_b_shift_out #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    port_b_shift_out_if.slave   bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_t;

    // capture path
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] last_req_q, last_req_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    // transfer path
    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] frame_q;
    logic [WIDTH-1:0] shadow_q;
    logic             ser_q;
    logic             sck_q;
    logic             rck_q;
    logic             busy_q;

    logic             capture;
    logic             consume;
    logic             tick;
    logic [WIDTH-1:0] shreg_next;

    // Bit presented on SER for a given shift register content.
    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Capture/consume arbitration: a new capture always wins over consumption.
    always_comb begin
        capture      = (in_q != last_req_q);
        consume      = (state_q == IDLE) && pend_valid_q && bus.enable;
        tick         = (div_q == DIV_LAST);
        shreg_next   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

        last_req_d   = last_req_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        drop_cnt_d   = drop_cnt_q;

        if (capture) begin
            last_req_d   = in_q;
            pend_data_d  = in_q;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !consume && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    // Input sampling and the single-entry pending slot; reset leaves a 0x00 frame pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q         <= '0;
            last_req_q   <= '0;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b1;
            drop_cnt_q   <= '0;
        end else begin
            in_q         <= bus.port_b_in;
            last_req_q   <= last_req_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Transfer FSM with registered SER/SCK/RCK; frame_q is snapped at consume so a
    // same-cycle capture cannot alter the frame already accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            frame_q   <= '0;
            shadow_q  <= '0;
            ser_q     <= 1'b0;
            sck_q     <= 1'b0;
            rck_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    ser_q <= 1'b0;
                    sck_q <= 1'b0;
                    rck_q <= 1'b0;
                    if (consume) begin
                        frame_q <= pend_data_q;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shreg_q   <= frame_q;
                    bit_cnt_q <= '0;
                    ser_q     <= lead_bit(frame_q);
                    div_q     <= '0;
                    state_q   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (tick) begin
                        div_q   <= '0;
                        sck_q   <= 1'b1;
                        state_q <= SHIFT_HI;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        div_q <= '0;
                        sck_q <= 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            rck_q   <= 1'b1;
                            state_q <= LATCH;
                        end else begin
                            shreg_q   <= shreg_next;
                            ser_q     <= lead_bit(shreg_next);
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            state_q   <= SHIFT_LO;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                LATCH: begin
                    if (tick) begin
                        div_q    <= '0;
                        rck_q    <= 1'b0;
                        ser_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        shadow_q <= frame_q;
                        state_q  <= IDLE;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    div_q   <= '0;
                    sck_q   <= 1'b0;
                    rck_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sr_ser   = ser_q;
    assign bus.sr_sck   = sck_q;
    assign bus.sr_rck   = rck_q;
    assign bus.busy     = busy_q;
    assign bus.shadow_q = shadow_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_port_b_shift_out.sv
// tb/tb_port_b_shift_out.sv - scoreboard bench for port_b_shift_out
module tb_port_b_shift_out;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    always #5 clk = ~clk;

    port_b_shift_out_if #(.WIDTH(8)) b1 ();
    port_b_shift_out_if #(.WIDTH(8)) b2 ();

    port_b_shift_out #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    port_b_shift_out #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (b2.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q1[$];
    logic [7:0] q2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // monitor state, dut (MSB first, CLK_DIV=4)
    logic [7:0] acc1;
    int         bits1, busy_len1, ov1, gl1;
    logic       p_sck1, p_rck1, p_busy1, p_ser1;

    // monitor state, dut2 (LSB first, CLK_DIV=1)
    logic [7:0] acc2;
    int         bits2, busy_len2, ov2, gl2;
    logic       p_sck2, p_rck2, p_busy2, p_ser2;

    initial begin
        acc1 = '0; bits1 = 0; busy_len1 = 0; ov1 = 0; gl1 = 0;
        p_sck1 = 0; p_rck1 = 0; p_busy1 = 0; p_ser1 = 0;
        acc2 = '0; bits2 = 0; busy_len2 = 0; ov2 = 0; gl2 = 0;
        p_sck2 = 0; p_rck2 = 0; p_busy2 = 0; p_ser2 = 0;
    end

    // Reassemble frames on SCK rises, compare on RCK fall, time busy.
    always @(negedge clk) begin
        if (rst) begin
            bits1 = 0; busy_len1 = 0; acc1 = '0;
            p_sck1 = 0; p_rck1 = 0; p_busy1 = 0; p_ser1 = 0;
        end else begin
            if (b1.sr_sck && b1.sr_rck) ov1++;
            if (p_sck1 && b1.sr_sck && (b1.sr_ser != p_ser1)) gl1++;
            if (b1.sr_sck && !p_sck1) begin
                acc1 = {acc1[6:0], b1.sr_ser};
                bits1++;
            end
            if (!b1.sr_rck && p_rck1) begin
                chk("sck_pulses1", bits1, 8);
                if (q1.size() == 0) begin
                    chk("frame1_unexpected", q1.size(), 1);
                end else begin
                    chk("frame1", acc1, q1[0]);
                    chk("shadow1", b1.shadow_q, q1[0]);
                    void'(q1.pop_front());
                end
                bits1 = 0;
            end
            if (b1.busy) busy_len1++;
            if (!b1.busy && p_busy1) begin
                chk("busy_len1", busy_len1, 69);
                busy_len1 = 0;
            end
            p_sck1 = b1.sr_sck; p_rck1 = b1.sr_rck; p_busy1 = b1.busy; p_ser1 = b1.sr_ser;
        end
    end

    always @(negedge clk) begin
        if (rst2) begin
            bits2 = 0; busy_len2 = 0; acc2 = '0;
            p_sck2 = 0; p_rck2 = 0; p_busy2 = 0; p_ser2 = 0;
        end else begin
            if (b2.sr_sck && b2.sr_rck) ov2++;
            if (p_sck2 && b2.sr_sck && (b2.sr_ser != p_ser2)) gl2++;
            if (b2.sr_sck && !p_sck2) begin
                acc2 = {b2.sr_ser, acc2[7:1]};
                bits2++;
            end
            if (!b2.sr_rck && p_rck2) begin
                chk("sck_pulses2", bits2, 8);
                if (q2.size() == 0) begin
                    chk("frame2_unexpected", q2.size(), 1);
                end else begin
                    chk("frame2", acc2, q2[0]);
                    chk("shadow2", b2.shadow_q, q2[0]);
                    void'(q2.pop_front());
                end
                bits2 = 0;
            end
            if (b2.busy) busy_len2++;
            if (!b2.busy && p_busy2) begin
                chk("busy_len2", busy_len2, 18);
                busy_len2 = 0;
            end
            p_sck2 = b2.sr_sck; p_rck2 = b2.sr_rck; p_busy2 = b2.busy; p_ser2 = b2.sr_ser;
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        int n;
        int r;
        int act;
        logic prev;

        rst = 1'b1;
        rst2 = 1'b1;
        b1.port_b_in = 8'h00;
        b1.enable = 1'b1;
        b2.port_b_in = 8'h00;
        b2.enable = 1'b1;
        q1.push_back(8'h00);
        q2.push_back(8'h00);

        // reset state
        cycles(3);
        #2;
        chk("reset_outputs1", {b1.sr_ser, b1.sr_sck, b1.sr_rck, b1.busy, b1.shadow_q, b1.drop_cnt}, 0);
        chk("reset_outputs2", {b2.sr_ser, b2.sr_sck, b2.sr_rck, b2.busy, b2.shadow_q, b2.drop_cnt}, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        rst2 = 1'b0;

        // init 0x00 transfers on both instances
        cycles(90);
        #1;
        chk("init_drained1", q1.size(), 0);
        chk("init_drained2", q2.size(), 0);
        chk("init_shadow1", b1.shadow_q, 8'h00);
        chk("init_drop1", b1.drop_cnt, 0);

        // LSB first, CLK_DIV=1, value 0x01
        q2.push_back(8'h01);
        b2.port_b_in = 8'h01;
        cycles(40);
        #1;
        chk("lsb_drained2", q2.size(), 0);
        chk("lsb_shadow2", b2.shadow_q, 8'h01);

        // 0xA5 with first-SCK latency
        @(posedge clk);
        #1;
        b1.port_b_in = 8'hA5;
        q1.push_back(8'hA5);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b1.sr_sck && n < 50);
        chk("a5_first_sck_latency", n - 1, 7);
        cycles(90);
        #1;
        chk("a5_drained", q1.size(), 0);
        chk("a5_shadow", b1.shadow_q, 8'hA5);

        // overwrite of a pending value during a 0x11 transfer
        b1.port_b_in = 8'h11;
        q1.push_back(8'h11);
        n = 0;
        while (!b1.busy && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_busy_start", b1.busy, 1);
        b1.port_b_in = 8'h22;
        cycles(10);
        #1;
        b1.port_b_in = 8'h33;
        q1.push_back(8'h33);
        cycles(10);
        cycles(200);
        #1;
        chk("t3_drained", q1.size(), 0);
        chk("t3_drop", b1.drop_cnt, 1);
        chk("t3_shadow", b1.shadow_q, 8'h33);

        // enable low blocks the start of a transfer
        b1.enable = 1'b0;
        b1.port_b_in = 8'h7E;
        act = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b1.sr_sck || b1.sr_rck || b1.busy) act++;
        end
        chk("t4_idle_activity", act, 0);
        chk("t4_shadow_held", b1.shadow_q, 8'h33);
        @(posedge clk);
        #1;
        q1.push_back(8'h7E);
        b1.enable = 1'b1;
        cycles(90);
        #1;
        chk("t4_drained", q1.size(), 0);
        chk("t4_shadow", b1.shadow_q, 8'h7E);
        chk("t4_drop", b1.drop_cnt, 1);

        // asynchronous reset after the third SCK rise of a 0xFF frame
        b1.port_b_in = 8'hFF;
        q1.push_back(8'hFF);
        r = 0;
        n = 0;
        prev = 1'b0;
        while (r < 3 && n < 100) begin
            @(posedge clk);
            #1;
            if (b1.sr_sck && !prev) r++;
            prev = b1.sr_sck;
            n++;
        end
        chk("t5_sck_rises", r, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_reset", {b1.sr_ser, b1.sr_sck, b1.sr_rck, b1.busy, b1.shadow_q, b1.drop_cnt}, 0);
        q1.delete();
        q1.push_back(8'h00);
        q1.push_back(8'hFF);
        cycles(3);
        #3;
        rst = 1'b0;
        cycles(200);
        #1;
        chk("t5_drained", q1.size(), 0);
        chk("t5_shadow", b1.shadow_q, 8'hFF);

        // input toggling every cycle with no consumption saturates the drop count
        b1.enable = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            b1.port_b_in = (i % 2 == 0) ? 8'h55 : 8'hAA;
        end
        cycles(3);
        #1;
        chk("t6_drop_saturated", b1.drop_cnt, 8'hFF);
        q1.push_back(8'hAA);
        b1.enable = 1'b1;
        cycles(90);
        #1;
        chk("t6_drained", q1.size(), 0);
        chk("t6_shadow", b1.shadow_q, 8'hAA);
        chk("t6_drop_held", b1.drop_cnt, 8'hFF);

        // glitch rules accumulated over the whole run
        chk("sck_rck_overlap1", ov1, 0);
        chk("ser_change_sck_high1", gl1, 0);
        chk("sck_rck_overlap2", ov2, 0);
        chk("ser_change_sck_high2", gl2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/port_b_shift_out.md
Name: port_b_shift_out

Overview:
- Sits directly downstream of the CPU's port B output register.
- Watches the 8-bit port B value and, whenever it changes, serialises it to an external 74HC595-style shift/latch register over SER/SCK/RCK.
- Holds one pending value while a transfer is in progress; newer changes overwrite it (last value wins) and each overwrite is counted.

Parameters:
- WIDTH, 8: width of port B data and of the serial frame.
- CLK_DIV, 4: clk cycles per SCK half-phase and per RCK high phase. Legal range is 1 and up.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- port_b_in  input  WIDTH  port B value from the CPU.
- enable  input  1  1 allows a new transfer to start.
- sr_ser  output  1  serial data to the external register.
- sr_sck  output  1  shift clock; the external part samples SER on the rising edge.
- sr_rck  output  1  storage-latch clock.
- busy  output  1  high from LOAD through LATCH.
- shadow_q  output  WIDTH  last value fully latched externally.
- drop_cnt  output  8  count of overwritten pending values; saturates at 255.

Behaviour:
- Reset (async, takes effect with no clock edge):
  - Outputs: sr_ser=0, sr_sck=0, sr_rck=0, busy=0, shadow_q=0, drop_cnt=0.
  - Internal: state=IDLE, in_q=0, last_req=0, pend_data=0, pend_valid=1.
  - Result: one transfer of 0x00 follows reset release, bringing the external part to a known state.
- Capture, every cycle:
  - in_q <= port_b_in.
  - If in_q != last_req: pend_data<=in_q, last_req<=in_q, pend_valid<=1.
  - If pend_valid was already 1 and is not being consumed this cycle, drop_cnt increments (saturating).
  - Capture runs regardless of enable and state.
- Consume: IDLE with pend_valid=1 and enable=1 moves to LOAD and clears pend_valid.
  - A capture in the same cycle wins: pend_valid stays 1 holding the new data, and no drop is counted.
- Divider: counts 0..CLK_DIV-1 only in SHIFT_LO, SHIFT_HI and LATCH. It resets on every state change. A "tick" is count==CLK_DIV-1.
- FSM:
  - IDLE: sck=0, rck=0, ser=0, busy=0.
  - LOAD (1 cycle): shreg<=pend_data, bit_cnt<=0, busy=1 → SHIFT_LO.
  - SHIFT_LO: sck=0; ser = current bit (shreg MSB if MSB_FIRST, else LSB). On tick → SHIFT_HI.
  - SHIFT_HI: sck=1, ser held. On tick:
    - if bit_cnt==WIDTH-1 → LATCH;
    - else shift shreg, bit_cnt++ → SHIFT_LO.
  - LATCH: sck=0, rck=1. On tick: shadow_q<=shreg original value (kept in a separate frame register), rck=0 → IDLE.
- Timing:
  - LOAD entry to IDLE return = 1 + (2·WIDTH+1)·CLK_DIV cycles. This is 69 cycles at the defaults.
  - port_b_in change (sampled at edge E0) gives LOAD at E2 and the first SCK rise at E3+CLK_DIV.
  - At least one IDLE cycle separates back-to-back transfers.
- Deassertion rules:
  - enable=0 never aborts an active transfer; it only blocks LOAD.
  - An input equal to last_req never starts a transfer, even if it differs from shadow_q.
- Reset mid-transfer: the frame is abandoned, outputs go to reset values immediately, and the 0x00 init transfer runs after release. The external part latches nothing from the partial frame because RCK never rose.
- Output glitches: sr_ser changes only while sr_sck=0; sr_rck is never high while sr_sck=1. All outputs are driven from flops.

Test Plan:
- Defaults, reset release, port_b_in=0, enable=1:
  - exactly 8 SCK pulses with ser=0, then one RCK pulse of 4 cycles;
  - busy high for 69 cycles; shadow_q=0x00; drop_cnt=0.
- After init, port_b_in=0xA5:
  - ser at the 8 SCK rises = 1,0,1,0,0,1,0,1;
  - first SCK rise 7 cycles after the sampling edge;
  - shadow_q=0xA5 after RCK falls.
- During a 0x11 transfer, apply 0x22 then 0x33, each held 10 cycles:
  - the next transfer is 0x33; 0x22 is never shifted;
  - drop_cnt=1; shadow_q ends at 0x33.
- enable=0, port_b_in=0x7E for 200 cycles:
  - SCK/RCK static, busy=0;
  - on enable=1, transfer 0x7E; shadow_q=0x7E.
- port_b_in=0xFF, assert rst asynchronously after the 3rd SCK rise:
  - all outputs 0 with no clock edge;
  - after release, transfer 0x00 then 0xFF; shadow_q=0xFF.
- MSB_FIRST=0, CLK_DIV=1, port_b_in=0x01:
  - ser=1 at the first SCK rise and 0 at the rest;
  - busy for 18 cycles.
- Toggle the input every cycle for 400 cycles: drop_cnt saturates at 255.
